// File: rtl/csr_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// csr_bank : RW / RO / W1C register bank with a single-outstanding bus port and a
// level interrupt. Optional set-only lock bit when CSR_BANK_LOCK_EN is defined.
// Revision : 1.0
// ----------------------------------------------------------------------------
module csr_bank #(
  parameter int unsigned                   DataWidth   = 16,
  parameter int unsigned                   RegCount    = 16,
  parameter logic [2*RegCount-1:0]         AccessMap   = '0,
  parameter logic [RegCount*DataWidth-1:0] ResetValues = '0,
  parameter int unsigned                   IrqStatIdx  = 9,
  parameter int unsigned                   IrqMaskIdx  = 8,
  parameter int unsigned                   LockIdx     = 15,
  localparam int unsigned                  AddrWidth   = (RegCount > 1) ? $clog2(RegCount) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_write_i,
  input  logic [AddrWidth-1:0]          req_addr_i,
  input  logic [DataWidth-1:0]          req_wdata_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output logic                          rsp_err_o,
  input  logic [RegCount-1:0]           hw_we_i,
  input  logic [RegCount*DataWidth-1:0] hw_data_i,
  output logic [RegCount*DataWidth-1:0] reg_o,
  output logic                          irq_o
);

  localparam logic [1:0] c_ACC_RW  = 2'b00;
  localparam logic [1:0] c_ACC_RO  = 2'b01;
  localparam logic [1:0] c_ACC_W1C = 2'b10;
  localparam logic [1:0] c_ACC_RSV = 2'b11;

  logic [DataWidth-1:0] r_regs [RegCount];
  logic [DataWidth-1:0] w_next [RegCount];

  logic                 r_rsp_valid;
  logic                 r_rsp_err;
  logic [DataWidth-1:0] r_rsp_rdata;

  logic                 w_accept;
  logic                 w_wr_ok;
  logic                 w_err;
  logic                 w_lock_block;
  logic [1:0]           w_acc;
  logic [DataWidth-1:0] w_rd_data;

  assign req_ready_o = !r_rsp_valid | rsp_ready_i;
  assign w_accept    = req_valid_i & req_ready_o;

  // Addresses past RegCount fall through to the reserved access type.
  always_comb begin
    w_acc     = c_ACC_RSV;
    w_rd_data = '0;
    for (int i = 0; i < RegCount; i++) begin
      if (req_addr_i == AddrWidth'(i)) begin
        w_acc     = AccessMap[2*i +: 2];
        w_rd_data = r_regs[i];
      end
    end
  end

`ifdef CSR_BANK_LOCK_EN
  logic w_locked;
  assign w_locked     = r_regs[LockIdx][0];
  assign w_lock_block = w_locked & (req_addr_i != AddrWidth'(LockIdx));
`else
  assign w_lock_block = 1'b0;
`endif

  assign w_err   = (w_acc == c_ACC_RSV)
                 | (req_write_i & (w_acc == c_ACC_RO))
                 | (req_write_i & (w_acc == c_ACC_RW) & w_lock_block);
  assign w_wr_ok = w_accept & req_write_i & ~w_err;

  // W1C: clear is applied first so a same-cycle hardware set wins.
  always_comb begin
    for (int i = 0; i < RegCount; i++) begin
      w_next[i] = r_regs[i];
      case (AccessMap[2*i +: 2])
        c_ACC_RW: begin
          if (w_wr_ok && (req_addr_i == AddrWidth'(i))) begin
            w_next[i] = req_wdata_i;
`ifdef CSR_BANK_LOCK_EN
            if (i == int'(LockIdx)) w_next[i][0] = req_wdata_i[0] | r_regs[i][0];
`endif
          end
        end
        c_ACC_RO: begin
          if (hw_we_i[i]) w_next[i] = hw_data_i[i*DataWidth +: DataWidth];
        end
        c_ACC_W1C: begin
          if (w_wr_ok && (req_addr_i == AddrWidth'(i))) w_next[i] = w_next[i] & ~req_wdata_i;
          if (hw_we_i[i]) w_next[i] = w_next[i] | hw_data_i[i*DataWidth +: DataWidth];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RegCount; i++) r_regs[i] <= ResetValues[i*DataWidth +: DataWidth];
    end else begin
      for (int i = 0; i < RegCount; i++) r_regs[i] <= w_next[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (!req_write_i && !w_err) ? w_rd_data : '0;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_rdata_o = r_rsp_rdata;

  always_comb begin
    reg_o = '0;
    for (int i = 0; i < RegCount; i++) reg_o[i*DataWidth +: DataWidth] = r_regs[i];
  end

  assign irq_o = |(r_regs[IrqStatIdx] & r_regs[IrqMaskIdx]);

endmodule
`default_nettype wire

// File: tb/tb_csr_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_csr_bank : directed + random stimulus against a behavioural CSR model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_csr_bank;

  localparam logic [31:0]  c_ACCMAP = 32'h0308_0100;  // r4 RO, r9 W1C, r12 reserved
  localparam logic [255:0] c_RV     = (256'h1111 << 32) | (256'hBEEF << 80);

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid_i, req_write_i, rsp_ready_i;
  logic [3:0]   req_addr_i;
  logic [15:0]  req_wdata_i, hw_we_i;
  logic [255:0] hw_data_i;
  logic         req_ready_o, rsp_valid_o, rsp_err_o, irq_o;
  logic [15:0]  rsp_rdata_o;
  logic [255:0] reg_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_regs [16];
  bit          m_vld, m_err;
  logic [15:0] m_rd;

  csr_bank #(
    .DataWidth(16), .RegCount(16), .AccessMap(c_ACCMAP), .ResetValues(c_RV),
    .IrqStatIdx(9), .IrqMaskIdx(8), .LockIdx(15)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .hw_we_i(hw_we_i), .hw_data_i(hw_data_i), .reg_o(reg_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // 0 RW, 1 RO, 2 W1C, 3 reserved
  function automatic int kind(input logic [3:0] a);
    case (a)
      4'd4:    return 1;
      4'd9:    return 2;
      4'd12:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [255:0] packed_regs();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = c_RV[i*16 +: 16];
    m_vld = 0; m_err = 0; m_rd = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rsp_valid"}, rsp_valid_o, m_vld);
    if (m_vld) begin
      chk({tag, ".rsp_err"}, rsp_err_o, m_err);
      chk({tag, ".rdata"}, rsp_rdata_o, m_rd);
    end
    chk({tag, ".regs"}, reg_o, packed_regs());
    chk({tag, ".irq"}, irq_o, |(m_regs[9] & m_regs[8]));
  endtask

  // One clock: drive inputs, predict the edge, then compare after it.
  task automatic step(input string tag, input bit v, input bit w, input logic [3:0] a,
                      input logic [15:0] d, input logic [15:0] hwe, input logic [255:0] hwd,
                      input bit rr);
    bit          acc, err, locked;
    logic [15:0] rd;
    logic [15:0] nx [16];
    req_valid_i = v; req_write_i = w; req_addr_i = a; req_wdata_i = d;
    hw_we_i = hwe; hw_data_i = hwd; rsp_ready_i = rr;
    #1;
    chk({tag, ".req_ready"}, req_ready_o, !m_vld || rr);
    acc = v && (!m_vld || rr);
    locked = 0;
`ifdef CSR_BANK_LOCK_EN
    locked = m_regs[15][0];
`endif
    err = (kind(a) == 3) || (w && kind(a) == 1) || (w && kind(a) == 0 && locked && a != 4'd15);
    rd  = (!w && !err) ? m_regs[a] : 16'h0;
    for (int i = 0; i < 16; i++) begin
      nx[i] = m_regs[i];
      if (kind(4'(i)) == 1 && hwe[i]) nx[i] = hwd[i*16 +: 16];
      if (kind(4'(i)) == 2) begin
        if (acc && w && a == 4'(i)) nx[i] = nx[i] & ~d;
        if (hwe[i]) nx[i] = nx[i] | hwd[i*16 +: 16];
      end
      if (kind(4'(i)) == 0 && acc && w && !err && a == 4'(i)) nx[i] = d;
    end
`ifdef CSR_BANK_LOCK_EN
    nx[15][0] = nx[15][0] | m_regs[15][0];
`endif
    @(posedge clk_i);
    #1;
    m_regs = nx;
    if (acc) begin m_vld = 1; m_err = err; m_rd = rd; end
    else if (rr) m_vld = 0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rsp_ready_i = 0; req_valid_i = 0; hw_we_i = '0;
    #2;
    rst_ni = 0;
    #1;
    model_reset();
    chk({tag, ".rst_valid"}, rsp_valid_o, 1'b0);
    chk({tag, ".rst_err"}, rsp_err_o, 1'b0);
    chk({tag, ".rst_rdata"}, rsp_rdata_o, 16'h0);
    chk({tag, ".rst_ready"}, req_ready_o, 1'b1);
    chk({tag, ".rst_regs"}, reg_o, c_RV);
    @(posedge clk_i);
    #3;
    rst_ni = 1;
  endtask

  initial begin
    rst_ni = 0; req_valid_i = 0; req_write_i = 0; req_addr_i = '0; req_wdata_i = '0;
    rsp_ready_i = 0; hw_we_i = '0; hw_data_i = '0;
    model_reset();
    @(posedge clk_i);
    #1;
    chk("reset.valid", rsp_valid_o, 1'b0);
    chk("reset.ready", req_ready_o, 1'b1);
    chk("reset.regs", reg_o, c_RV);
    chk("reset.irq", irq_o, 1'b0);
    #2;
    rst_ni = 1;

    // RW round trip
    step("rt_wr", 1, 1, 4'd2, 16'hA5C3, '0, '0, 1);
    chk("rt_wr.err", rsp_err_o, 1'b0);
    step("rt_rd", 1, 0, 4'd2, 16'h0, '0, '0, 1);
    chk("rt_rd.valid", rsp_valid_o, 1'b1);
    chk("rt_rd.rdata", rsp_rdata_o, 16'hA5C3);

    // W1C set/clear collision
    step("w1c_set", 0, 0, 4'd0, 16'h0, 16'h0200, 256'h00F0 << 144, 1);
    chk("w1c_set.r9", reg_o[159:144], 16'h00F0);
    step("w1c_col", 1, 1, 4'd9, 16'h0030, 16'h0200, 256'h0010 << 144, 1);
    chk("w1c_col.r9", reg_o[159:144], 16'h00D0);

    // Interrupt
    step("irq_mask", 1, 1, 4'd8, 16'h0004, '0, '0, 1);
    step("irq_set", 0, 0, 4'd0, 16'h0, 16'h0200, 256'h0004 << 144, 1);
    chk("irq_set.irq", irq_o, 1'b1);
    step("irq_clr", 1, 1, 4'd9, 16'h0004, '0, '0, 1);
    chk("irq_clr.irq", irq_o, 1'b0);

    // Backpressure: response held, request stalled, accepted on release edge
    step("bp_rd", 1, 0, 4'd2, 16'h0, '0, '0, 1);
    for (int k = 0; k < 3; k++) begin
      step("bp_hold", 1, 0, 4'd8, 16'h0, '0, '0, 0);
      chk("bp_hold.ready", req_ready_o, 1'b0);
      chk("bp_hold.rdata", rsp_rdata_o, 16'hA5C3);
    end
    step("bp_rel", 1, 0, 4'd8, 16'h0, '0, '0, 1);
    chk("bp_rel.rdata", rsp_rdata_o, 16'h0004);

    // RO write and reserved read
    step("ro_wr", 1, 1, 4'd4, 16'hFFFF, '0, '0, 1);
    chk("ro_wr.err", rsp_err_o, 1'b1);
    chk("ro_wr.r4", reg_o[79:64], 16'h0000);
    step("rsv_rd", 1, 0, 4'd12, 16'h0, '0, '0, 1);
    chk("rsv_rd.err", rsp_err_o, 1'b1);
    chk("rsv_rd.rdata", rsp_rdata_o, 16'h0000);

    // Reset with a response still pending
    step("pend_rd", 1, 0, 4'd5, 16'h0, '0, '0, 1);
    chk("pend_rd.rdata", rsp_rdata_o, 16'hBEEF);
    do_reset("mid");

`ifdef CSR_BANK_LOCK_EN
    step("lk_set", 1, 1, 4'd15, 16'h0001, '0, '0, 1);
    step("lk_wr", 1, 1, 4'd2, 16'h1234, '0, '0, 1);
    chk("lk_wr.err", rsp_err_o, 1'b1);
    chk("lk_wr.r2", reg_o[47:32], 16'h1111);
    step("lk_clr", 1, 1, 4'd15, 16'h0000, '0, '0, 1);
    chk("lk_clr.bit", reg_o[240], 1'b1);
    do_reset("lk");
`endif

    for (int n = 0; n < 400; n++) begin
      step("rnd", 1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
           16'($urandom & $urandom & $urandom),
           {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_bank.md
CSR_BANK -- requirements
Module: csr_bank

Interface
REQ-001 SHALL have parameter DataWidth, default 16: width of every register and data bus.
REQ-002 SHALL have parameter RegCount, default 16: number of registers; AddrWidth = $clog2(RegCount).
REQ-003 SHALL have parameter AccessMap, default all 2'b00: 2 bits per register; 00 RW, 01 RO (hardware-loaded), 10 W1C (hardware-set status), 11 reserved.
REQ-004 SHALL have parameter ResetValues, default all zero: RegCount*DataWidth reset image.
REQ-005 SHALL have parameter IrqStatIdx, default 9: index of the W1C status register used for interrupts.
REQ-006 SHALL have parameter IrqMaskIdx, default 8: index of the RW mask register used for interrupts.
REQ-007 SHALL have parameter LockIdx, default 15: index of the lock register, used only when the lock feature is compiled in.
REQ-008 SHALL have ports, one per line:
- clk_i, in, 1: the only clock.
- rst_ni, in, 1: asynchronous, active-low reset.
- req_valid_i, in, 1: bus request valid.
- req_ready_o, out, 1: bus request ready.
- req_write_i, in, 1: 1 = write, 0 = read.
- req_addr_i, in, AddrWidth: register index.
- req_wdata_i, in, DataWidth: write data.
- rsp_valid_o, out, 1: response valid.
- rsp_ready_i, in, 1: response consumed.
- rsp_rdata_o, out, DataWidth: read data; 0 on writes and errors.
- rsp_err_o, out, 1: access error.
- hw_we_i, in, RegCount: per-register hardware strobe.
- hw_data_i, in, RegCount*DataWidth: hardware load or set data.
- reg_o, out, RegCount*DataWidth: live register contents.
- irq_o, out, 1: level interrupt.

Function
REQ-009 SHALL accept a request on a rising edge where req_valid_i & req_ready_o.
REQ-010 SHALL drive req_ready_o = !rsp_valid_o | rsp_ready_i, allowing one outstanding request and back-to-back accepts.
REQ-011 SHALL assert rsp_valid_o the cycle after accept and hold it, with rsp_rdata_o and rsp_err_o stable, until rsp_ready_i is high.
REQ-012 SHALL return, for a read, the register value sampled at the accept edge, before any update made on that edge.
REQ-013 SHALL update a RW register with req_wdata_i on the accept edge of a write.
REQ-014 SHALL ignore writes to RO registers and SHALL flag them with rsp_err_o=1.
REQ-015 SHALL load a RO register with hw_data_i on the same edge when hw_we_i is set.
REQ-016 SHALL treat software writes to W1C registers as clear-on-1: reg &= ~wdata.
REQ-017 SHALL treat hw_we_i to a W1C register as OR-set: reg |= hw_data.
REQ-018 SHALL give set priority over clear when both hit the same W1C bit in the same cycle.
REQ-019 SHALL ignore hw_we_i on RW registers.
REQ-020 SHALL complete accesses to a reserved entry (AccessMap=11) or to addresses >= RegCount with rsp_err_o=1, rdata 0 and no state change.
REQ-021 SHALL drive irq_o = |(reg[IrqStatIdx] & reg[IrqMaskIdx]), combinational from registered state, so irq_o follows register changes with no added latency.

Reset
REQ-022 SHALL, while rst_ni is low, set every register to its ResetValues slice and drive rsp_valid_o=0, rsp_err_o=0 and rsp_rdata_o=0.
REQ-023 SHALL drive req_ready_o=1 once rsp_valid_o is cleared by reset.
REQ-024 SHALL, on reset asserted mid-transaction, drop a pending response without completing it.

Configuration
REQ-025 SHALL, when CSR_BANK_LOCK_EN is defined, make bit 0 of register LockIdx a set-only lock.
REQ-026 SHALL, while that lock bit is 1, ignore writes to RW registers other than LockIdx and answer them with rsp_err_o=1.
REQ-027 SHALL keep the lock bit set until reset.
REQ-028 SHALL keep W1C clears and hardware updates unaffected by the lock.
REQ-029 SHALL, when CSR_BANK_LOCK_EN is undefined, treat LockIdx as an ordinary register per AccessMap and instantiate no lock logic.

Verification
REQ-030 SHALL cover a RW round trip: write 0xA5C3 to addr 2, then read addr 2 -> rsp_rdata_o=0xA5C3, rsp_err_o=0, each response one cycle after its accept.
REQ-031 SHALL cover W1C set/clear collision: reg 9 = 0x00F0; in the same cycle hw_we_i[9] with data 0x0010 and a software write of 0x0030 -> reg 9 = 0x00D0.
REQ-032 SHALL cover the interrupt: mask reg 8 = 0x0004, then hw set 0x0004 on reg 9 -> irq_o=1; write 0x0004 to reg 9 -> irq_o=0 on the following cycle.
REQ-033 SHALL cover backpressure: hold rsp_ready_i=0 for 3 cycles after a read -> req_ready_o=0 and response fields stable throughout; release -> next request accepted on that same edge.
REQ-034 SHALL cover RO and reserved addresses: write to a RO register -> rsp_err_o=1 and value unchanged; read of a reserved entry -> rsp_err_o=1, rdata 0x0000.
REQ-035 SHALL cover the lock (CSR_BANK_LOCK_EN defined): write 1 to reg 15, then write 0x1234 to reg 2 -> rsp_err_o=1 and reg 2 unchanged; assert rst_ni low -> lock and reg 2 return to their reset values.
